// File: rtl/load_fetch_unit_if.sv
// Bundled load-request, memory-read and result signals of the load fetch unit.
// slave: the fetch unit itself; master: the core/memory/translator side driving it.
interface load_fetch_unit_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [1:0]            ld_size;
  logic                  ld_sign_ext;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [1:0]            out_addr_key;
  logic [1:0]            out_size;
  logic                  out_sign_ext;
  logic                  busy;
  logic                  ld_error;

  modport slave (
    input  ld_valid, ld_addr, ld_size, ld_sign_ext, mem_gnt, mem_rvalid, mem_rdata, out_ready,
    output ld_ready, mem_req, mem_addr, out_valid, out_data, out_addr_key, out_size,
           out_sign_ext, busy, ld_error
  );

  modport master (
    output ld_valid, ld_addr, ld_size, ld_sign_ext, mem_gnt, mem_rvalid, mem_rdata, out_ready,
    input  ld_ready, mem_req, mem_addr, out_valid, out_data, out_addr_key, out_size,
           out_sign_ext, busy, ld_error
  );
endinterface

// File: rtl/load_fetch_unit.sv
// Load path front end: one outstanding word-aligned read over req/gnt + rvalid, result held
// for the translator. Define LOAD_TIMEOUT_EN to abort loads that exceed TIMEOUT cycles.
module load_fetch_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic              clk,
  input logic              reset,
  load_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  capture;
  logic                  timeout;

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("TIMEOUT must be non-zero");
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    capture       = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          capture = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        // An aborting request is withdrawn so no grant can land on a dead load.
        bus.mem_req = ~timeout;
        if (timeout) begin
          data_d  = '0;
          state_d = StResp;
        end else if (bus.mem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          data_d  = bus.mem_rdata;
          state_d = StResp;
        end else if (timeout) begin
          data_d  = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          bus.ld_ready = 1'b1;
          if (bus.ld_valid) begin
            capture = 1'b1;
            state_d = StReq;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (capture) begin
        addr_q <= bus.ld_addr;
        size_q <= bus.ld_size;
        sign_q <= bus.ld_sign_ext;
      end
    end
  end

  assign bus.mem_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.out_data     = data_q;
  assign bus.out_addr_key = addr_q[1:0];
  assign bus.out_size     = size_q;
  assign bus.out_sign_ext = sign_q;
  assign bus.busy         = (state_q != StIdle);

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            in_flight;

  assign in_flight = (state_q == StReq) || (state_q == StWait);
  // Fires on the TIMEOUT-th REQ/WAIT cycle, counting the first REQ cycle as zero.
  assign timeout   = in_flight && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (capture) begin
        cnt_q <= '0;
      end else if (in_flight) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Returning data in the timeout cycle wins over the abort.
      if ((state_q == StResp) && bus.out_ready) begin
        err_q <= 1'b0;
      end else if (timeout && !((state_q == StWait) && bus.mem_rvalid)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.ld_error = err_q;
`else
  assign timeout      = 1'b0;
  assign bus.ld_error = 1'b0;
`endif

endmodule

// File: tb/tb_load_fetch_unit.sv
// Bench for load_fetch_unit: directed vector table, corner-case sequences and a randomized
// run checked against a transaction-level model.
module tb_load_fetch_unit;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned TIMEOUT    = 15;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  load_fetch_unit_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) lf ();

  load_fetch_unit #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    int          ord_dly;
    logic [31:0] exp_maddr;
    logic [1:0]  exp_key;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    lf.ld_valid    = 1'b0;
    lf.ld_addr     = '0;
    lf.ld_size     = '0;
    lf.ld_sign_ext = 1'b0;
    lf.mem_gnt     = 1'b0;
    lf.mem_rvalid  = 1'b0;
    lf.mem_rdata   = '0;
    lf.out_ready   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    @(negedge clk);
    lf.ld_valid = 1'b1; lf.ld_addr = v.addr; lf.ld_size = v.size; lf.ld_sign_ext = v.sign;
    #1 chk("accept_ready", lf.ld_ready, 1);
    @(negedge clk);
    lf.ld_valid = 1'b0; lf.ld_addr = $urandom; lf.ld_size = 2'($urandom);
    for (int i = 0; i < v.gnt_dly; i++) begin
      #1 chk("req_held", lf.mem_req, 1);
      chk("req_addr_held", lf.mem_addr, v.exp_maddr);
      chk("req_not_ready", lf.ld_ready, 0);
      @(negedge clk);
    end
    // rvalid alongside gnt must not be taken as the read data
    lf.mem_gnt = 1'b1; lf.mem_rvalid = 1'b1; lf.mem_rdata = ~v.rdata;
    #1 chk("req_gnt", lf.mem_req, 1);
    chk("mem_addr", lf.mem_addr, v.exp_maddr);
    @(negedge clk);
    lf.mem_gnt = 1'b0; lf.mem_rvalid = 1'b0;
    for (int i = 0; i < v.rv_dly; i++) begin
      #1 chk("wait_no_req", lf.mem_req, 0);
      chk("wait_no_out", lf.out_valid, 0);
      chk("wait_busy", lf.busy, 1);
      @(negedge clk);
    end
    lf.mem_rvalid = 1'b1; lf.mem_rdata = v.rdata;
    #1 chk("rvalid_no_out_yet", lf.out_valid, 0);
    @(negedge clk);
    lf.mem_rvalid = 1'b0;
    for (int i = 0; i < v.ord_dly; i++) begin
      lf.mem_rvalid = 1'b1; lf.mem_rdata = $urandom;
      #1 chk("stall_valid", lf.out_valid, 1);
      chk("stall_data", lf.out_data, v.rdata);
      chk("stall_not_ready", lf.ld_ready, 0);
      @(negedge clk);
      lf.mem_rvalid = 1'b0;
    end
    lf.out_ready = 1'b1;
    #1 chk("out_valid", lf.out_valid, 1);
    chk("out_data", lf.out_data, v.rdata);
    chk("out_key", lf.out_addr_key, v.exp_key);
    chk("out_size", lf.out_size, v.size);
    chk("out_sign", lf.out_sign_ext, v.sign);
    chk("out_ld_ready", lf.ld_ready, 1);
    chk("out_no_error", lf.ld_error, 0);
    @(negedge clk);
    lf.out_ready = 1'b0;
    #1 chk("after_idle_valid", lf.out_valid, 0);
    chk("after_idle_busy", lf.busy, 0);
  endtask

  vec_t vecs[5];

  // Transaction-level model state for the randomized run
  bit          m_pend, m_gnt, m_res, m_err;
  int          m_cnt;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_size;
  logic        m_sign;

  initial begin
    vecs[0] = '{32'h0000_0100, 2'b11, 1'b1, 32'hA1B2_C3D4, 0, 0, 0, 32'h0000_0100, 2'b00};
    vecs[1] = '{32'h0000_0107, 2'b01, 1'b0, 32'h5566_7788, 0, 0, 0, 32'h0000_0104, 2'b11};
    vecs[2] = '{32'h0000_2002, 2'b01, 1'b1, 32'hDEAD_BEEF, 4, 2, 3, 32'h0000_2000, 2'b10};
    vecs[3] = '{32'hFFFF_FFFD, 2'b00, 1'b0, 32'h0123_4567, 1, 1, 1, 32'hFFFF_FFFC, 2'b01};
    vecs[4] = '{32'h8000_0001, 2'b10, 1'b1, 32'hCAFE_F00D, 0, 3, 0, 32'h8000_0000, 2'b01};

    reset = 1'b1;
    idle_inputs();
    #12;
    chk("rst_ld_ready", lf.ld_ready, 1);
    chk("rst_mem_req", lf.mem_req, 0);
    chk("rst_mem_addr", lf.mem_addr, 0);
    chk("rst_out_valid", lf.out_valid, 0);
    chk("rst_out_data", lf.out_data, 0);
    chk("rst_out_key", {lf.out_addr_key, lf.out_size, lf.out_sign_ext}, 0);
    chk("rst_busy", lf.busy, 0);
    chk("rst_error", lf.ld_error, 0);
    @(negedge clk);
    reset = 1'b0;

    // Stray rvalid while idle
    @(negedge clk);
    lf.mem_rvalid = 1'b1; lf.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    lf.mem_rvalid = 1'b0;
    #1 chk("stray_busy", lf.busy, 0);
    chk("stray_out_valid", lf.out_valid, 0);
    chk("stray_out_data", lf.out_data, 0);

    for (int i = 0; i < 5; i++) run_load(vecs[i]);

    // Back-to-back: second request accepted in the result cycle
    @(negedge clk);
    lf.ld_valid = 1'b1; lf.ld_addr = 32'h40; lf.ld_size = 2'b10; lf.ld_sign_ext = 1'b0;
    #1 chk("b2b_accept_a", lf.ld_ready, 1);
    @(negedge clk);
    lf.ld_addr = 32'h1233; lf.ld_size = 2'b11; lf.ld_sign_ext = 1'b1; lf.mem_gnt = 1'b1;
    #1 chk("b2b_addr_a", lf.mem_addr, 32'h40);
    @(negedge clk);
    lf.mem_gnt = 1'b0; lf.mem_rvalid = 1'b1; lf.mem_rdata = 32'h1111_2222;
    @(negedge clk);
    lf.mem_rvalid = 1'b0; lf.out_ready = 1'b1;
    #1 chk("b2b_data_a", lf.out_data, 32'h1111_2222);
    chk("b2b_ready_in_resp", lf.ld_ready, 1);
    @(negedge clk);
    lf.mem_gnt = 1'b1;
    #1 chk("b2b_no_bubble", {lf.busy, lf.mem_req, lf.out_valid}, 3'b110);
    chk("b2b_addr_b", lf.mem_addr, 32'h1230);
    @(negedge clk);
    lf.ld_valid = 1'b0; lf.mem_gnt = 1'b0; lf.mem_rvalid = 1'b1; lf.mem_rdata = 32'h3333_4444;
    @(negedge clk);
    lf.mem_rvalid = 1'b0;
    #1 chk("b2b_data_b", lf.out_data, 32'h3333_4444);
    chk("b2b_key_b", {lf.out_valid, lf.out_addr_key, lf.out_size, lf.out_sign_ext}, 6'b111111);
    @(negedge clk);
    lf.out_ready = 1'b0;
    #1 chk("b2b_done", lf.busy, 0);

    // Reset while waiting for data, then a late rvalid
    do_reset();
    @(negedge clk);
    lf.ld_valid = 1'b1; lf.ld_addr = 32'h300;
    @(negedge clk);
    lf.ld_valid = 1'b0; lf.mem_gnt = 1'b1;
    @(negedge clk);
    lf.mem_gnt = 1'b0;
    #1 chk("rw_in_wait", lf.busy, 1);
    #1 reset = 1'b1;
    #1 chk("rw_async", {lf.busy, lf.out_valid, lf.mem_req, lf.ld_ready}, 4'b0001);
    @(negedge clk);
    reset = 1'b0; lf.mem_rvalid = 1'b1; lf.mem_rdata = 32'h7777_8888;
    @(negedge clk);
    lf.mem_rvalid = 1'b0;
    #1 chk("rw_late_ignored", {lf.busy, lf.out_valid}, 2'b00);
    chk("rw_no_capture", lf.out_data, 0);

`ifdef LOAD_TIMEOUT_EN
    begin
      int n;
      do_reset();
      @(negedge clk);
      lf.ld_valid = 1'b1; lf.ld_addr = 32'h500;
      @(negedge clk);
      lf.ld_valid = 1'b0;
      n = 0;
      forever begin
        #1;
        if (lf.out_valid || n >= 40) break;
        n++;
        @(negedge clk);
      end
      chk("tmo_latency", n, TIMEOUT);
      chk("tmo_error", lf.ld_error, 1);
      chk("tmo_data", lf.out_data, 0);
      chk("tmo_req_low", lf.mem_req, 0);
      @(negedge clk);
      lf.out_ready = 1'b1;
      @(negedge clk);
      lf.out_ready = 1'b0;
      #1 chk("tmo_error_cleared", lf.ld_error, 0);
    end
`endif

    // Randomized run against the model
    do_reset();
    m_pend = 0; m_gnt = 0; m_res = 0; m_err = 0; m_cnt = 0;
    m_addr = '0; m_data = '0; m_size = '0; m_sign = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit tmo, e_req, e_rdy, waiting;
      @(negedge clk);
      lf.ld_valid    = ($urandom_range(0, 1) == 1);
      lf.ld_addr     = $urandom;
      lf.ld_size     = 2'($urandom);
      lf.ld_sign_ext = 1'($urandom);
      lf.mem_gnt     = ($urandom_range(0, 2) != 0);
      lf.mem_rvalid  = ($urandom_range(0, 2) != 0);
      lf.mem_rdata   = $urandom;
      lf.out_ready   = ($urandom_range(0, 1) == 1);
      #1;
      waiting = m_pend && !m_res;
      tmo = 0;
`ifdef LOAD_TIMEOUT_EN
      tmo = waiting && (m_cnt == TIMEOUT - 1);
`endif
      e_req = waiting && !m_gnt && !tmo;
      e_rdy = !m_pend || (m_res && lf.out_ready);
      chk("rnd_ld_ready", lf.ld_ready, e_rdy);
      chk("rnd_mem_req", lf.mem_req, e_req);
      chk("rnd_busy", lf.busy, m_pend);
      chk("rnd_out_valid", lf.out_valid, m_res);
      if (e_req) chk("rnd_mem_addr", lf.mem_addr, {m_addr[31:2], 2'b00});
      if (m_res) begin
        chk("rnd_out_data", lf.out_data, m_data);
        chk("rnd_out_meta", {lf.out_addr_key, lf.out_size, lf.out_sign_ext},
            {m_addr[1:0], m_size, m_sign});
        chk("rnd_ld_error", lf.ld_error, m_err);
      end
      if (m_res && lf.out_ready) begin
        m_pend = 0; m_res = 0; m_err = 0;
      end else if (waiting) begin
        if (m_gnt && lf.mem_rvalid) begin
          m_res = 1; m_data = lf.mem_rdata; m_err = 0;
        end else if (tmo) begin
          m_res = 1; m_data = '0; m_err = 1;
        end else if (!m_gnt && lf.mem_gnt) begin
          m_gnt = 1;
        end
        m_cnt++;
      end
      if (e_rdy && lf.ld_valid) begin
        m_pend = 1; m_gnt = 0; m_res = 0; m_cnt = 0;
        m_addr = lf.ld_addr; m_size = lf.ld_size; m_sign = lf.ld_sign_ext;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
